// File: rtl/processador_pkg.sv
// Shared definitions for the 10-bit-instruction processor.
// Used by the sequencer, the decoder and the instruction ROM.
package processador_pkg;

    localparam int PC_W    = 5;
    localparam int INSTR_W = 10;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_RST = 4'b0111;
    localparam logic [3:0] OP_INC = 4'b1000;
    localparam logic [3:0] OP_JMP = 4'b1001;
    localparam logic [3:0] OP_JZ  = 4'b1010;
    localparam logic [3:0] OP_DEC = 4'b1011;
    localparam logic [3:0] OP_SHL = 4'b1100;
    localparam logic [3:0] OP_ST  = 4'b1101;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_IN  = 4'b1111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_WAIT_EXT,
        ST_EXEC
    } seq_state_t;

    // ALU-producing opcodes refresh the zero flag; control and I/O opcodes leave it alone.
    function automatic logic op_updates_zero(input logic [3:0] op);
        logic upd;
        upd = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT, OP_SHR,
            OP_INC, OP_DEC, OP_SHL: upd = 1'b1;
            default:                upd = 1'b0;
        endcase
        return upd;
    endfunction

endpackage

// File: rtl/sequenciador_controle.sv
// Fetch/execute sequencer: owns pc, instruction register, zero flag and the
// external-nibble handshake; exec_en qualifies all datapath writes.
//
// state    | meaning
// IDLE     | parked, waits for run
// FETCH    | pc presented to instruction memory
// LOAD     | memory data captured into instr
// WAIT_EXT | IN opcode, waiting for ext_valid
// EXEC     | exec_en high; pc, flag and retired counter update
module sequenciador_controle #(
    parameter int PC_W    = 5,
    parameter int INSTR_W = 10,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instr,
    output logic               exec_en,
    input  logic               zero_alu,
    output logic               zero_flag,
    input  logic               ext_valid,
    input  logic [3:0]         ext_data,
    output logic               ext_ready,
    output logic [3:0]         ext_nibble,
    output logic               busy,
    output logic [CNT_W-1:0]   retired
);
    import processador_pkg::*;

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [PC_W-1:0]     pc;
    logic [PC_W-1:0]     pc_nxt;
    logic                zero_nxt;
    logic [3:0]          opcode;
    logic [3:0]          load_opcode;
    logic [PC_W-1:0]     target;

    assign opcode      = instr[INSTR_W-1 -: 4];
    assign load_opcode = imem_data[INSTR_W-1 -: 4];
    assign target      = instr[PC_W-1:0];

    assign imem_addr = pc;
    assign exec_en   = (state == ST_EXEC);
    assign ext_ready = (state == ST_WAIT_EXT);
    assign busy      = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        zero_nxt  = zero_flag;
        case (state)
            ST_IDLE:     if (run) state_nxt = ST_FETCH;
            ST_FETCH:    state_nxt = ST_LOAD;
            ST_LOAD:     state_nxt = (load_opcode == OP_IN) ? ST_WAIT_EXT : ST_EXEC;
            ST_WAIT_EXT: if (ext_valid) state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt = run ? ST_FETCH : ST_IDLE;
                case (opcode)
                    OP_JMP:  pc_nxt = target;
                    OP_JZ:   pc_nxt = zero_flag ? target : pc + PC_W'(1);
                    OP_RST:  pc_nxt = '0;
                    default: pc_nxt = pc + PC_W'(1);
                endcase
                if (op_updates_zero(opcode))
                    zero_nxt = zero_alu;
                else if (opcode == OP_RST)
                    zero_nxt = 1'b0;
            end
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            pc         <= '0;
            instr      <= '0;
            zero_flag  <= 1'b0;
            ext_nibble <= 4'h0;
            retired    <= '0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            zero_flag <= zero_nxt;
            if (state == ST_LOAD)
                instr <= imem_data;
            // ext_valid outside WAIT_EXT never reaches the nibble register
            if (state == ST_WAIT_EXT && ext_valid)
                ext_nibble <= ext_data;
            if (state == ST_EXEC)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_sequenciador_controle.sv
// Bench for sequenciador_controle: directed program plus random instruction
// stream, checked against an instruction-level model of pc/flag/counter.
module tb_sequenciador_controle;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [4:0] imem_addr;
    logic [9:0] imem_data;
    logic [9:0] instr;
    logic       exec_en;
    logic       zero_alu;
    logic       zero_flag;
    logic       ext_valid;
    logic [3:0] ext_data;
    logic       ext_ready;
    logic [3:0] ext_nibble;
    logic       busy;
    logic [7:0] retired;

    logic [9:0] rom [32];

    int n_assert = 0;
    int n_fail   = 0;

    int         m_pc;
    int         m_ret;
    logic       m_zf;
    logic [3:0] m_nib;

    sequenciador_controle #(.PC_W(5), .INSTR_W(10), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr      (instr),
        .exec_en    (exec_en),
        .zero_alu   (zero_alu),
        .zero_flag  (zero_flag),
        .ext_valid  (ext_valid),
        .ext_data   (ext_data),
        .ext_ready  (ext_ready),
        .ext_nibble (ext_nibble),
        .busy       (busy),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in IDLE or EXEC with run = 1; returns during the EXEC cycle.
    task automatic do_instr(input int ext_wait, input logic [3:0] nib, input logic zalu,
                            input logic run_after, input logic drop_in_load);
        logic [9:0] ins;
        int op, tgt, np;
        ins = rom[m_pc];
        tick();
        chk("fetch_busy",    32'(busy), 32'd1);
        chk("fetch_addr",    32'(imem_addr), 32'(m_pc));
        chk("fetch_exec",    32'(exec_en), 32'd0);
        chk("retired",       32'(retired), 32'(m_ret));
        chk("zero_flag",     32'(zero_flag), 32'(m_zf));
        ext_valid = 1'($urandom_range(0, 1));
        ext_data  = 4'($urandom);
        tick();
        chk("load_addr",     32'(imem_addr), 32'(m_pc));
        chk("load_exec",     32'(exec_en), 32'd0);
        chk("load_ready",    32'(ext_ready), 32'd0);
        ext_valid = 1'($urandom_range(0, 1));
        ext_data  = 4'($urandom);
        if (drop_in_load) run = 1'b0;
        tick();
        if (ins[9:6] == 4'hF) begin
            for (int i = 0; i < ext_wait; i++) begin
                ext_valid = 1'b0;
                ext_data  = 4'($urandom);
                chk("wait_ready", 32'(ext_ready), 32'd1);
                chk("wait_exec",  32'(exec_en), 32'd0);
                tick();
            end
            chk("hs_ready", 32'(ext_ready), 32'd1);
            chk("hs_exec",  32'(exec_en), 32'd0);
            ext_valid = 1'b1;
            ext_data  = nib;
            tick();
            ext_valid = 1'b0;
            m_nib = nib;
        end
        chk("exec_en",     32'(exec_en), 32'd1);
        chk("exec_ready",  32'(ext_ready), 32'd0);
        chk("exec_instr",  32'(instr), 32'(ins));
        chk("exec_nibble", 32'(ext_nibble), 32'(m_nib));
        zero_alu  = zalu;
        run       = run_after;
        ext_valid = 1'($urandom_range(0, 1));
        op  = int'(ins[9:6]);
        tgt = int'(ins[4:0]);
        if (op == 9)       np = tgt;
        else if (op == 10) np = m_zf ? tgt : (m_pc + 1) % 32;
        else if (op == 7)  np = 0;
        else               np = (m_pc + 1) % 32;
        if (op <= 6 || op == 8 || op == 11 || op == 12) m_zf = zalu;
        else if (op == 7)                               m_zf = 1'b0;
        m_pc  = np;
        m_ret = (m_ret + 1) % 256;
    endtask

    task automatic park();
        tick();
        ext_valid = 1'b0;
        chk("park_busy",    32'(busy), 32'd0);
        chk("park_exec",    32'(exec_en), 32'd0);
        chk("park_ready",   32'(ext_ready), 32'd0);
        chk("park_pc",      32'(imem_addr), 32'(m_pc));
        chk("park_retired", 32'(retired), 32'(m_ret));
        chk("park_zf",      32'(zero_flag), 32'(m_zf));
        tick();
        chk("stay_idle",    32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        run   = 1'b0;
        tick();
        tick();
        m_pc = 0; m_ret = 0; m_zf = 1'b0; m_nib = 4'h0;
        chk("rst_pc",      32'(imem_addr), 32'd0);
        chk("rst_instr",   32'(instr), 32'd0);
        chk("rst_exec",    32'(exec_en), 32'd0);
        chk("rst_ready",   32'(ext_ready), 32'd0);
        chk("rst_nibble",  32'(ext_nibble), 32'd0);
        chk("rst_zf",      32'(zero_flag), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_busy",    32'(busy), 32'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; zero_alu = 1'b0; ext_valid = 1'b0; ext_data = 4'h0;
        for (int i = 0; i < 32; i++) rom[i] = 10'b0000_00_01_10;
        rom[1]  = {4'b1010, 1'b0, 5'd10};
        rom[2]  = {4'b1001, 1'b0, 5'b10111};
        rom[23] = 10'b0001_00_01_10;
        rom[24] = {4'b1010, 1'b0, 5'd30};
        rom[30] = {4'b1111, 6'd0};
        rom[31] = 10'b0000_00_01_10;

        do_reset();
        tick();
        chk("idle_no_run", 32'(busy), 32'd0);

        // first instruction alone: exec_en only in the third cycle after run
        run = 1'b1;
        do_instr(0, 4'h0, 1'b0, 1'b0, 1'b0);
        park();

        run = 1'b1;
        do_instr(0, 4'h0, 1'b1, 1'b1, 1'b0);   // JZ, flag 0 -> pc 2
        do_instr(0, 4'h0, 1'b1, 1'b1, 1'b0);   // JMP 23
        do_instr(0, 4'h0, 1'b1, 1'b1, 1'b0);   // SUB, zero_alu = 1
        do_instr(0, 4'h0, 1'b0, 1'b1, 1'b0);   // JZ taken -> 30
        do_instr(5, 4'hA, 1'b1, 1'b1, 1'b0);   // IN after 5 idle cycles
        do_instr(0, 4'h0, 1'b1, 1'b1, 1'b0);   // ADD at 31 wraps to 0
        do_instr(0, 4'h0, 1'b0, 1'b0, 1'b1);   // run dropped during LOAD
        park();

        for (int i = 0; i < 32; i++) rom[i] = 10'($urandom_range(0, 1023));
        run = 1'b1;
        for (int k = 0; k < 40; k++)
            do_instr($urandom_range(0, 3), 4'($urandom), 1'($urandom_range(0, 1)),
                     (k != 39), 1'b0);
        park();

        // reset while waiting for the external nibble
        do_reset();
        rom[0] = {4'b1111, 6'd0};
        run = 1'b1;
        tick();
        tick();
        tick();
        chk("midwait_ready", 32'(ext_ready), 32'd1);
        tick();
        rst_n = 1'b0;
        ext_valid = 1'b1;
        ext_data  = 4'h5;
        tick();
        chk("midrst_ready",   32'(ext_ready), 32'd0);
        chk("midrst_pc",      32'(imem_addr), 32'd0);
        chk("midrst_exec",    32'(exec_en), 32'd0);
        chk("midrst_retired", 32'(retired), 32'd0);
        chk("midrst_busy",    32'(busy), 32'd0);
        chk("midrst_nibble",  32'(ext_nibble), 32'd0);
        chk("midrst_instr",   32'(instr), 32'd0);
        run = 1'b0;
        ext_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy",    32'(busy), 32'd0);
        chk("post_rst_retired", 32'(retired), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
